// File: rtl/sound_comm_pkg.sv
// Shared constants for the 68K<->Z80 sound communication sequencer:
// Z80 I/O port codes (address bits [4:2]) and the NMI sequencer states.
package sound_comm_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PORT_W = 3;

  localparam logic [PORT_W-1:0] PORT_CMD_RD   = 3'b000;
  localparam logic [PORT_W-1:0] PORT_NMI_EN   = 3'b010;
  localparam logic [PORT_W-1:0] PORT_REPLY_WR = 3'b011;
  localparam logic [PORT_W-1:0] PORT_NMI_DIS  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/comm_strobe_sync.sv
// Two-flop synchroniser for an asynchronous CPU strobe, followed by a
// registered rising-edge detector that emits a one-cycle event pulse.
module comm_strobe_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= strobe_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sound_comm_ctrl.sv
// 68K<->Z80 sound communication: command latch, reply latch, status flags
// and the Z80 NMI sequencer, driven by synchronised CPU strobe events.
module sound_comm_ctrl
  import sound_comm_pkg::*;
#(
  parameter int unsigned NMI_PULSE_CYC = 8
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       nICOMZONE,
  input  logic       RW,
  input  logic [7:0] M68K_DIN,
  output logic [7:0] M68K_DOUT,
  output logic       M68K_DOE,
  input  logic       Z80_nIORQ,
  input  logic       Z80_nRD,
  input  logic       Z80_nWR,
  input  logic [4:0] Z80_A,
  input  logic [7:0] Z80_DIN,
  output logic [7:0] Z80_DOUT,
  output logic       Z80_DOE,
  output logic       nZ80_NMI,
  output logic       CMD_PENDING,
  output logic       REPLY_VALID,
  output logic       CMD_OVERRUN
);

  logic m68k_wr_ev;
  logic m68k_rd_ev;
  logic z80_rd_ev;
  logic z80_wr_ev;

  comm_strobe_sync u_sync_m68k_wr (
    .clk_i(CLK_24M), .rst_i(RESET), .strobe_i(~nICOMZONE & ~RW), .pulse_o(m68k_wr_ev)
  );
  comm_strobe_sync u_sync_m68k_rd (
    .clk_i(CLK_24M), .rst_i(RESET), .strobe_i(~nICOMZONE & RW), .pulse_o(m68k_rd_ev)
  );
  comm_strobe_sync u_sync_z80_rd (
    .clk_i(CLK_24M), .rst_i(RESET), .strobe_i(~Z80_nIORQ & ~Z80_nRD), .pulse_o(z80_rd_ev)
  );
  comm_strobe_sync u_sync_z80_wr (
    .clk_i(CLK_24M), .rst_i(RESET), .strobe_i(~Z80_nIORQ & ~Z80_nWR), .pulse_o(z80_wr_ev)
  );

  // Port decode uses only A[4:2]; the address is stable on the event cycle.
  logic [PORT_W-1:0] port_c;
  logic              ack_c;
  logic              reply_wr_c;
  logic              nmi_en_set_c;
  logic              nmi_dis_c;
  logic              unused_z80_a;

  assign port_c       = Z80_A[4:2];
  assign ack_c        = z80_rd_ev && (port_c == PORT_CMD_RD);
  assign reply_wr_c   = z80_wr_ev && (port_c == PORT_REPLY_WR);
  assign nmi_en_set_c = z80_wr_ev && (port_c == PORT_NMI_EN);
  assign nmi_dis_c    = z80_wr_ev && (port_c == PORT_NMI_DIS);
  assign unused_z80_a = ^Z80_A[1:0];

  logic [7:0]       cmd_q;
  logic [7:0]       reply_q;
  logic             pending_q;
  logic             reply_valid_q;
  logic             overrun_q;
  logic             nmi_en_q;
  logic             nmi_n_q;
  logic [CNT_W-1:0] cnt_q;
  nmi_state_e       state_q;

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      cmd_q         <= 8'h00;
      reply_q       <= 8'h00;
      pending_q     <= 1'b0;
      reply_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      nmi_en_q      <= 1'b0;
      nmi_n_q       <= 1'b1;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
    end else begin
      // A new write wins over a same-cycle ack, so the command stays pending.
      if (m68k_wr_ev) begin
        cmd_q     <= M68K_DIN;
        pending_q <= 1'b1;
        if (pending_q && !ack_c) overrun_q <= 1'b1;
      end else if (ack_c) begin
        pending_q <= 1'b0;
      end

      if (reply_wr_c) begin
        reply_q       <= Z80_DIN;
        reply_valid_q <= 1'b1;
      end else if (m68k_rd_ev) begin
        reply_valid_q <= 1'b0;
      end

      if (nmi_en_set_c)   nmi_en_q <= 1'b1;
      else if (nmi_dis_c) nmi_en_q <= 1'b0;

      if (nmi_dis_c) begin
        state_q <= ST_IDLE;
        nmi_n_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (m68k_wr_ev && nmi_en_q) begin
              state_q <= ST_PULSE;
              cnt_q   <= CNT_W'(NMI_PULSE_CYC - 1);
              nmi_n_q <= 1'b0;
            end
          end
          ST_PULSE: begin
            if (cnt_q == '0) begin
              state_q <= ST_WAIT_ACK;
              nmi_n_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_WAIT_ACK: begin
            if (ack_c) begin
              if (m68k_wr_ev && nmi_en_q) begin
                state_q <= ST_PULSE;
                cnt_q   <= CNT_W'(NMI_PULSE_CYC - 1);
                nmi_n_q <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            nmi_n_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign M68K_DOUT   = reply_q;
  assign Z80_DOUT    = cmd_q;
  assign CMD_PENDING = pending_q;
  assign REPLY_VALID = reply_valid_q;
  assign CMD_OVERRUN = overrun_q;
  assign nZ80_NMI    = nmi_n_q;
  assign M68K_DOE    = RW & ~nICOMZONE;
  assign Z80_DOE     = ~Z80_nIORQ & ~Z80_nRD & (Z80_A[3:2] == 2'b00);

endmodule

// File: tb/tb_sound_comm_ctrl.sv
// Bench for sound_comm_ctrl: event-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sound_comm_ctrl;

  localparam int NMI_N = 8;

  logic       clk;
  logic       RESET;
  logic       nICOMZONE;
  logic       RW;
  logic [7:0] M68K_DIN;
  logic [7:0] M68K_DOUT;
  logic       M68K_DOE;
  logic       Z80_nIORQ;
  logic       Z80_nRD;
  logic       Z80_nWR;
  logic [4:0] Z80_A;
  logic [7:0] Z80_DIN;
  logic [7:0] Z80_DOUT;
  logic       Z80_DOE;
  logic       nZ80_NMI;
  logic       CMD_PENDING;
  logic       REPLY_VALID;
  logic       CMD_OVERRUN;

  sound_comm_ctrl #(.NMI_PULSE_CYC(NMI_N)) dut (
    .CLK_24M(clk), .RESET(RESET),
    .nICOMZONE(nICOMZONE), .RW(RW), .M68K_DIN(M68K_DIN),
    .M68K_DOUT(M68K_DOUT), .M68K_DOE(M68K_DOE),
    .Z80_nIORQ(Z80_nIORQ), .Z80_nRD(Z80_nRD), .Z80_nWR(Z80_nWR),
    .Z80_A(Z80_A), .Z80_DIN(Z80_DIN), .Z80_DOUT(Z80_DOUT), .Z80_DOE(Z80_DOE),
    .nZ80_NMI(nZ80_NMI), .CMD_PENDING(CMD_PENDING),
    .REPLY_VALID(REPLY_VALID), .CMD_OVERRUN(CMD_OVERRUN)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an event fires when the raw strobe was seen high three
  // edges ago after being low four edges ago; effects land on that edge.
  logic [7:0] m_cmd, m_reply;
  logic       m_pend, m_rv, m_ovr, m_en, m_wait;
  int         m_low;
  logic [3:0] h_w, h_r, h_zr, h_zw;

  always @(posedge clk) begin : model
    logic ev_w, ev_r, ev_zr, ev_zw, ack, rwr, en_set, dis, fire;
    if (RESET) begin
      m_cmd = 8'h00; m_reply = 8'h00;
      m_pend = 1'b0; m_rv = 1'b0; m_ovr = 1'b0; m_en = 1'b0; m_wait = 1'b0;
      m_low = 0;
      h_w = 4'b0; h_r = 4'b0; h_zr = 4'b0; h_zw = 4'b0;
    end else begin
      ev_w   = h_w[2] & ~h_w[3];
      ev_r   = h_r[2] & ~h_r[3];
      ev_zr  = h_zr[2] & ~h_zr[3];
      ev_zw  = h_zw[2] & ~h_zw[3];
      ack    = ev_zr && (Z80_A[4:2] == 3'b000);
      rwr    = ev_zw && (Z80_A[4:2] == 3'b011);
      en_set = ev_zw && (Z80_A[4:2] == 3'b010);
      dis    = ev_zw && (Z80_A[4:2] == 3'b110);
      fire   = 1'b0;
      // NMI: low for NMI_N cycles, then outstanding until the Z80 acks.
      if (dis) begin
        m_low = 0; m_wait = 1'b0;
      end else if (m_low > 0) begin
        m_low--;
        if (m_low == 0) m_wait = 1'b1;
      end else if (m_wait) begin
        if (ack) begin
          m_wait = 1'b0;
          fire = ev_w && m_en;
        end
      end else begin
        fire = ev_w && m_en;
      end
      if (fire) m_low = NMI_N;
      if (ev_w) begin
        if (m_pend && !ack) m_ovr = 1'b1;
        m_cmd = M68K_DIN;
        m_pend = 1'b1;
      end else if (ack) begin
        m_pend = 1'b0;
      end
      if (rwr) begin
        m_reply = Z80_DIN; m_rv = 1'b1;
      end else if (ev_r) begin
        m_rv = 1'b0;
      end
      if (en_set) m_en = 1'b1;
      else if (dis) m_en = 1'b0;
      h_w  = {h_w[2:0],  ~nICOMZONE & ~RW};
      h_r  = {h_r[2:0],  ~nICOMZONE & RW};
      h_zr = {h_zr[2:0], ~Z80_nIORQ & ~Z80_nRD};
      h_zw = {h_zw[2:0], ~Z80_nIORQ & ~Z80_nWR};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("z80_dout",    32'(Z80_DOUT),    32'(m_cmd));
      check("m68k_dout",   32'(M68K_DOUT),   32'(m_reply));
      check("cmd_pending", 32'(CMD_PENDING), 32'(m_pend));
      check("reply_valid", 32'(REPLY_VALID), 32'(m_rv));
      check("cmd_overrun", 32'(CMD_OVERRUN), 32'(m_ovr));
      check("nz80_nmi",    32'(nZ80_NMI),    32'((m_low > 0) ? 1'b0 : 1'b1));
      check("m68k_doe",    32'(M68K_DOE),    32'(RW & ~nICOMZONE));
      check("z80_doe",     32'(Z80_DOE),     32'(~Z80_nIORQ & ~Z80_nRD & (Z80_A[3:2] == 2'b00)));
    end
  end

  // NMI pulse monitor: start cycle, length and count of completed pulses.
  bit in_low = 1'b0;
  int low_start = 0;
  int low_len = 0;
  int last_len = 0;
  int pulses = 0;

  always @(negedge clk) begin
    if (nZ80_NMI === 1'b0) begin
      if (!in_low) begin
        in_low = 1'b1; low_start = cyc; low_len = 0;
      end
      low_len++;
    end else if (in_low) begin
      in_low = 1'b0; last_len = low_len; pulses++;
    end
  end

  int wr_cyc = 0;
  logic [7:0] smp_dout;
  logic       smp_doe;

  task automatic m68k_access(input logic rd, input logic [7:0] d);
    @(negedge clk); #2;
    nICOMZONE = 1'b0; RW = rd; M68K_DIN = d; wr_cyc = cyc;
    repeat (3) @(negedge clk);
    #1 smp_dout = M68K_DOUT; smp_doe = M68K_DOE;
    repeat (3) @(negedge clk);
    #2 nICOMZONE = 1'b1; RW = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic z80_access(input logic rd, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); #2;
    Z80_A = a; Z80_DIN = d; Z80_nIORQ = 1'b0;
    if (rd) Z80_nRD = 1'b0; else Z80_nWR = 1'b0;
    repeat (3) @(negedge clk);
    #1 smp_dout = Z80_DOUT; smp_doe = Z80_DOE;
    repeat (3) @(negedge clk);
    #2 Z80_nIORQ = 1'b1; Z80_nRD = 1'b1; Z80_nWR = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 RESET = 1'b1;
    repeat (2) @(negedge clk);
    #2 RESET = 1'b0;
    @(negedge clk);
  endtask

  int p0;
  bit seen;

  initial begin
    RESET = 1'b1; nICOMZONE = 1'b1; RW = 1'b1; M68K_DIN = 8'h00;
    Z80_nIORQ = 1'b1; Z80_nRD = 1'b1; Z80_nWR = 1'b1; Z80_A = 5'h00; Z80_DIN = 8'h00;
    repeat (3) @(negedge clk);
    #2 RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    check("rst_z80_dout", 32'(Z80_DOUT), 32'h00);
    check("rst_flags", 32'({CMD_PENDING, REPLY_VALID, CMD_OVERRUN, nZ80_NMI}), 32'b0001);

    // Enable NMI, command 0x5A, pulse timing, ack.
    z80_access(1'b0, 5'h08, 8'h00);
    m68k_access(1'b0, 8'h5A);
    repeat (4) @(negedge clk); #1;
    check("t1_cmd", 32'(Z80_DOUT), 32'h5A);
    check("t1_pending", 32'(CMD_PENDING), 32'h1);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_nmi_len", 32'(last_len), 32'd8);
    check("t1_nmi_start", 32'(low_start - wr_cyc), 32'd4);
    z80_access(1'b1, 5'h04, 8'h00);
    check("t1_doe_port4", 32'(smp_doe), 32'h0);
    check("t1_no_ack_port4", 32'(CMD_PENDING), 32'h1);
    z80_access(1'b1, 5'h00, 8'h00);
    check("t1_doe_read", 32'({smp_doe, smp_dout}), 32'h15A);
    check("t1_acked", 32'(CMD_PENDING), 32'h0);

    // Disabled NMI: command pends without pulse; enabling later is silent.
    z80_access(1'b0, 5'h18, 8'h00);
    m68k_access(1'b0, 8'h11);
    check("t2_pending", 32'(CMD_PENDING), 32'h1);
    z80_access(1'b0, 5'h08, 8'h00);
    repeat (10) @(negedge clk); #1;
    check("t2_no_nmi", 32'(pulses), 32'd1);
    check("t2_nmi_high", 32'(nZ80_NMI), 32'h1);

    // Two writes without ack: overrun, single pulse.
    z80_access(1'b1, 5'h00, 8'h00);
    p0 = pulses;
    m68k_access(1'b0, 8'h01);
    m68k_access(1'b0, 8'h02);
    repeat (10) @(negedge clk); #1;
    check("t3_cmd", 32'(Z80_DOUT), 32'h02);
    check("t3_overrun", 32'(CMD_OVERRUN), 32'h1);
    check("t3_one_pulse", 32'(pulses - p0), 32'd1);

    // Reply path.
    z80_access(1'b0, 5'h0C, 8'hA5);
    check("t4_reply_valid", 32'(REPLY_VALID), 32'h1);
    m68k_access(1'b1, 8'h00);
    check("t4_read_bus", 32'({smp_doe, smp_dout}), 32'h1A5);
    check("t4_reply_cleared", 32'(REPLY_VALID), 32'h0);

    // Ack and new command in the same event cycle.
    do_reset();
    z80_access(1'b0, 5'h08, 8'h00);
    m68k_access(1'b0, 8'h20);
    repeat (6) @(negedge clk);
    p0 = pulses;
    @(negedge clk); #2;
    nICOMZONE = 1'b0; RW = 1'b0; M68K_DIN = 8'h33;
    Z80_A = 5'h00; Z80_nIORQ = 1'b0; Z80_nRD = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk); #1;
      if (nZ80_NMI == 1'b0) seen = 1'b1;
    end
    check("t5_nmi_fired", 32'(seen), 32'h1);
    check("t5_state", 32'({Z80_DOUT, CMD_PENDING, CMD_OVERRUN}), 32'({8'h33, 1'b1, 1'b0}));

    // Reset on the third cycle of that pulse.
    repeat (2) @(negedge clk);
    #2;
    nICOMZONE = 1'b1; RW = 1'b1; Z80_nIORQ = 1'b1; Z80_nRD = 1'b1;
    RESET = 1'b1;
    @(negedge clk); #1;
    check("t6_nmi_high", 32'(nZ80_NMI), 32'h1);
    check("t6_flags", 32'({CMD_PENDING, REPLY_VALID, CMD_OVERRUN, Z80_DOUT}), 32'h0);
    check("t6_pulse_len", 32'(last_len), 32'd3);
    #1 RESET = 1'b0;
    p0 = pulses;
    m68k_access(1'b0, 8'h44);
    repeat (10) @(negedge clk); #1;
    check("t6_nmi_en_cleared", 32'(pulses - p0), 32'd0);
    check("t6_pending", 32'({CMD_PENDING, Z80_DOUT}), 32'h144);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
